// File: rtl/noc_pkg.sv
// Shared NoC definitions: VC selection encodings and width helpers for
// per-VC buffering blocks.
package noc_pkg;

    localparam int VC_SEL_EXT     = 0;   // VC taken from vc_plane_selector
    localparam int VC_SEL_HDR     = 1;   // VC taken from a flit header field
    localparam int DEFAULT_VC_LSB = 28;

    // A single-VC configuration still needs a 1-bit selector port.
    function automatic int vcw_of(input int vc);
        return (vc <= 1) ? 1 : $clog2(vc);
    endfunction

    // Occupancy counters must represent 0..DEPTH inclusive.
    function automatic int cw_of(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vc_flit_fifo.sv
// Single-VC flit FIFO with an occupancy counter.
// The head flit is presented combinationally from the read pointer.
module vc_flit_fifo
    import noc_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int CW         = cw_of(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-2:0]         wr_ptr;
    logic [CW-2:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH for free.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vc_buffered_demux.sv
// Input-port VC demultiplexer: steers each accepted flit into one of VC
// per-VC FIFOs; only the addressed VC being full backpressures the input.
module vc_buffered_demux
    import noc_pkg::*;
#(
    parameter  int VC         = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    parameter  int SEL_MODE   = VC_SEL_EXT,
    parameter  int VC_LSB     = DEFAULT_VC_LSB,
    localparam int VCW        = vcw_of(VC),
    localparam int CW         = cw_of(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VCW-1:0]           vc_plane_selector,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic [VC*DATA_WIDTH-1:0] data_out_vc,
    output logic [VC-1:0]            valid_out_vc,
    input  logic [VC-1:0]            ready_out_vc,
    output logic [VC*CW-1:0]         occupancy_vc,
    output logic                     vc_err
);

    // Handshake: a transfer completes on a rising edge where valid and ready
    // are both high; ready never depends on valid, and a held valid with
    // changing select simply retargets the pending flit.

    logic [VCW-1:0]      sel;
    logic                sel_ok;
    logic [VC-1:0]       full;
    logic [VC-1:0]       empty;
    logic [VC-1:0]       push_en;
    logic [2**VCW-1:0]   full_pad;

    assign sel = (SEL_MODE == VC_SEL_HDR) ? data_in[VC_LSB +: VCW] : vc_plane_selector;

    generate
        if (VC == 2**VCW) begin : g_sel_full_range
            assign sel_ok = 1'b1;
        end else begin : g_sel_partial_range
            assign sel_ok = (int'(sel) < VC);
        end
    endgenerate

    // Unused selector codes read as full so they can never be accepted.
    always_comb begin
        full_pad          = '1;
        full_pad[VC-1:0]  = full;
    end

    assign ready_in = !rst && sel_ok && !full_pad[sel];

    generate
        for (genvar v = 0; v < VC; v++) begin : g_vc
            assign push_en[v]      = valid_in && ready_in && (sel == VCW'(v));
            assign valid_out_vc[v] = !empty[v];

            vc_flit_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (push_en[v]),
                .push_data (data_in),
                .pop       (ready_out_vc[v]),
                .head      (data_out_vc[v*DATA_WIDTH +: DATA_WIDTH]),
                .full      (full[v]),
                .empty     (empty[v]),
                .count     (occupancy_vc[v*CW +: CW])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vc_err <= 1'b0;
        end else if (valid_in && !sel_ok) begin
            vc_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vc_buffered_demux.sv
// Bench for vc_buffered_demux: three configurations (external select, header
// select with 4 VCs, header select with 3 VCs) against a queue-based model.
module tb_vc_buffered_demux;
    import noc_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int NDUT  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Per-instance stimulus and padded views of the outputs.
    logic [DW-1:0]  din_a  [NDUT];
    logic           vin_a  [NDUT];
    logic [1:0]     psel_a [NDUT];
    logic [3:0]     rout_a [NDUT];
    logic           rdy_a  [NDUT];
    logic           err_a  [NDUT];
    logic [3:0]     vout_a [NDUT];
    logic [4*DW-1:0] dout_a [NDUT];
    logic [4*CW-1:0] occ_a  [NDUT];

    logic           rdy0, rdy1, rdy2, err0, err1, err2;
    logic [3:0]     vout0, vout1;
    logic [2:0]     vout2;
    logic [4*DW-1:0] dout0, dout1;
    logic [3*DW-1:0] dout2;
    logic [4*CW-1:0] occ0, occ1;
    logic [3*CW-1:0] occ2;

    vc_buffered_demux #(.VC(4), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SEL_MODE(VC_SEL_EXT), .VC_LSB(28)) u_dut0 (
        .clk(clk), .rst(rst), .vc_plane_selector(psel_a[0]), .data_in(din_a[0]), .valid_in(vin_a[0]),
        .ready_in(rdy0), .data_out_vc(dout0), .valid_out_vc(vout0), .ready_out_vc(rout_a[0]),
        .occupancy_vc(occ0), .vc_err(err0));

    vc_buffered_demux #(.VC(4), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SEL_MODE(VC_SEL_HDR), .VC_LSB(28)) u_dut1 (
        .clk(clk), .rst(rst), .vc_plane_selector(psel_a[1]), .data_in(din_a[1]), .valid_in(vin_a[1]),
        .ready_in(rdy1), .data_out_vc(dout1), .valid_out_vc(vout1), .ready_out_vc(rout_a[1]),
        .occupancy_vc(occ1), .vc_err(err1));

    vc_buffered_demux #(.VC(3), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SEL_MODE(VC_SEL_HDR), .VC_LSB(28)) u_dut2 (
        .clk(clk), .rst(rst), .vc_plane_selector(psel_a[2]), .data_in(din_a[2]), .valid_in(vin_a[2]),
        .ready_in(rdy2), .data_out_vc(dout2), .valid_out_vc(vout2), .ready_out_vc(rout_a[2][2:0]),
        .occupancy_vc(occ2), .vc_err(err2));

    assign rdy_a[0] = rdy0;  assign rdy_a[1] = rdy1;  assign rdy_a[2] = rdy2;
    assign err_a[0] = err0;  assign err_a[1] = err1;  assign err_a[2] = err2;
    assign vout_a[0] = vout0; assign vout_a[1] = vout1; assign vout_a[2] = {1'b0, vout2};
    assign dout_a[0] = dout0; assign dout_a[1] = dout1; assign dout_a[2] = {{DW{1'b0}}, dout2};
    assign occ_a[0] = occ0;  assign occ_a[1] = occ1;  assign occ_a[2] = {{CW{1'b0}}, occ2};

    // Reference model: one FIFO queue per VC per instance plus a sticky error bit.
    logic [DW-1:0] exp_q [NDUT][4][$];
    logic          err_m    [NDUT];
    logic          acc_last [NDUT];
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nvc(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic logic [1:0] sel_of(input int d);
        return (d == 0) ? psel_a[0] : din_a[d][29:28];
    endfunction

    function automatic logic model_ready(input int d);
        logic [1:0] s;
        s = sel_of(d);
        if (rst) return 1'b0;
        if (int'(s) >= nvc(d)) return 1'b0;
        return exp_q[d][s].size() < DEPTH;
    endfunction

    task automatic check_outputs();
        for (int d = 0; d < NDUT; d++) begin
            for (int v = 0; v < nvc(d); v++) begin
                check_eq($sformatf("d%0d valid_out[%0d]", d, v), vout_a[d][v], exp_q[d][v].size() > 0);
                check_eq($sformatf("d%0d occupancy[%0d]", d, v), occ_a[d][v*CW +: CW], exp_q[d][v].size());
                if (exp_q[d][v].size() > 0)
                    check_eq($sformatf("d%0d data_out[%0d]", d, v), dout_a[d][v*DW +: DW], exp_q[d][v][0]);
            end
            check_eq($sformatf("d%0d vc_err", d), err_a[d], err_m[d]);
        end
    endtask

    // One clock cycle: check ready, predict the handshakes, clock, update model, check outputs.
    task automatic step();
        logic          acc  [NDUT];
        logic          bad  [NDUT];
        logic [1:0]    s    [NDUT];
        logic [DW-1:0] dat  [NDUT];
        logic [3:0]    pops [NDUT];
        logic          rst_s;
        #1;
        rst_s = rst;
        for (int d = 0; d < NDUT; d++) begin
            s[d]   = sel_of(d);
            dat[d] = din_a[d];
            check_eq($sformatf("d%0d ready_in", d), rdy_a[d], model_ready(d));
            acc[d] = vin_a[d] && model_ready(d);
            bad[d] = vin_a[d] && (int'(s[d]) >= nvc(d));
            pops[d] = '0;
            for (int v = 0; v < nvc(d); v++)
                pops[d][v] = rout_a[d][v] && (exp_q[d][v].size() > 0);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            if (rst_s) begin
                for (int v = 0; v < 4; v++) exp_q[d][v].delete();
                err_m[d] = 1'b0;
            end else begin
                for (int v = 0; v < nvc(d); v++)
                    if (pops[d][v]) void'(exp_q[d][v].pop_front());
                if (acc[d]) exp_q[d][s[d]].push_back(dat[d]);
                if (bad[d]) err_m[d] = 1'b1;
            end
            acc_last[d] = acc[d];
        end
        check_outputs();
    endtask

    task automatic idle_all();
        for (int d = 0; d < NDUT; d++) begin
            vin_a[d]  = 1'b0;
            rout_a[d] = '0;
            psel_a[d] = '0;
            din_a[d]  = '0;
        end
    endtask

    function automatic logic [DW-1:0] hdr_flit(input logic [1:0] id);
        logic [DW-1:0] f;
        f = $urandom();
        f[29:28] = id;
        return f;
    endfunction

    initial begin
        rst = 1'b1;
        idle_all();
        for (int d = 0; d < NDUT; d++) begin
            err_m[d] = 1'b0;
            acc_last[d] = 1'b0;
        end

        // Reset held three cycles, then a quiet cycle.
        repeat (3) step();
        rst = 1'b0;
        step();
        check_eq("reset ready_in d0", rdy0, 1'b1);
        check_eq("reset occupancy d0", occ0, '0);

        // External select onto VC2.
        psel_a[0] = 2'd2; vin_a[0] = 1'b1; din_a[0] = 32'hA1; step();
        din_a[0] = 32'hA2; step();
        vin_a[0] = 1'b0; step();
        check_eq("t2 valid_out", vout0, 4'b0100);
        check_eq("t2 occ vc2", occ0[2*CW +: CW], 3'd2);
        check_eq("t2 head vc2", dout0[2*DW +: DW], 32'hA1);
        rout_a[0] = 4'b0100; step();
        rout_a[0] = 4'b0000;
        check_eq("t2 head after pop", dout0[2*DW +: DW], 32'hA2);
        rout_a[0] = 4'b0100; step();
        rout_a[0] = 4'b0000;

        // Fill VC1, then pop while a fifth flit waits.
        psel_a[0] = 2'd1; vin_a[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din_a[0] = 32'hB0 + i;
            step();
        end
        din_a[0] = 32'hB4;
        #1 check_eq("t3 full vc1 ready", rdy0, 1'b0);
        psel_a[0] = 2'd0;
        #1 check_eq("t3 vc0 ready", rdy0, 1'b1);
        psel_a[0] = 2'd1;
        rout_a[0] = 4'b0010; step();
        rout_a[0] = 4'b0000;
        check_eq("t3 ready after pop", rdy0, 1'b1);
        step();
        vin_a[0] = 1'b0; rout_a[0] = 4'b0010;
        repeat (5) step();
        rout_a[0] = 4'b0000;

        // Header-selected ids 3,0,3,1, then concurrent drain.
        vin_a[1] = 1'b1;
        din_a[1] = hdr_flit(2'd3); step();
        din_a[1] = hdr_flit(2'd0); step();
        din_a[1] = hdr_flit(2'd3); step();
        din_a[1] = hdr_flit(2'd1); step();
        vin_a[1] = 1'b0; step();
        check_eq("t4 occupancy", occ1, {3'd2, 3'd0, 3'd1, 3'd1});
        rout_a[1] = 4'b1111;
        repeat (3) step();
        rout_a[1] = 4'b0000;

        // Out-of-range header id on the 3-VC instance.
        vin_a[2] = 1'b1; din_a[2] = hdr_flit(2'd3); step();
        check_eq("t5 vc_err set", err2, 1'b1);
        vin_a[2] = 1'b0; din_a[2] = hdr_flit(2'd0);
        repeat (2) step();
        check_eq("t5 vc_err sticky", err2, 1'b1);

        // Reset while VC0 holds two flits and is being popped.
        psel_a[0] = 2'd0; vin_a[0] = 1'b1;
        din_a[0] = 32'hC0; step();
        din_a[0] = 32'hC1; step();
        vin_a[0] = 1'b0; rout_a[0] = 4'b0001; rst = 1'b1; step();
        rst = 1'b0; step();
        check_eq("t6 valid after rst", vout0, 4'b0000);
        check_eq("t6 vc_err cleared", err2, 1'b0);
        rout_a[0] = 4'b0000;

        // Randomized traffic, alternating light and heavy downstream backpressure.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int d = 0; d < NDUT; d++) begin
                logic hold;
                hold = vin_a[d] && !acc_last[d] && (int'(sel_of(d)) < nvc(d));
                if (!hold) begin
                    vin_a[d] = ($urandom_range(0, 3) != 0);
                    if (d == 2)
                        din_a[d] = hdr_flit(($urandom_range(0, 39) == 0) ? 2'd3 : 2'($urandom_range(0, 2)));
                    else
                        din_a[d] = hdr_flit(2'($urandom_range(0, 3)));
                end
                if (d == 0 && $urandom_range(0, 3) == 0) psel_a[0] = 2'($urandom_range(0, 3));
                else if (d != 0) psel_a[d] = 2'($urandom_range(0, 3));
                rout_a[d] = ((cyc / 150) % 2 == 0) ? 4'($urandom() & $urandom()) : 4'($urandom_range(0, 15));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
